hnf_tag_array: RTL and testbench
================================

HNF_TAG_ARRAY -- requirements
Module: hnf_tag_array

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- IDX_W, 6, index width; depth = 2**IDX_W sets.
- CLINE_W, 28, tag-entry width per way.
- WAY_NUM, 4, number of ways.
- RD_LAT, 1, read latency in cycles; legal values are 1 or 2.
- INIT_EN, 1, when 1, an automatic zero-sweep runs after reset.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock.
- rst, in, 1, reset; asynchronous, active-low.
- init_req, in, 1, single-cycle pulse that requests a re-sweep of all sets to zero.
- req_valid, in, 1, request present.
- req_ready, out, 1, block accepts a request this cycle.
- req_index, in, IDX_W, set index.
- req_rd_en, in, 1, read all ways of the set.
- req_wr_ways, in, WAY_NUM, per-way write mask.
- req_wr_cline, in, CLINE_W, write data, replicated to every masked way.
- rd_valid, out, 1, read data valid.
- rd_clines, out, CLINE_W*WAY_NUM, read data; way i occupies bits [i*CLINE_W +: CLINE_W].
- init_busy, out, 1, a sweep is in progress.
- init_done, out, 1, at least one sweep has completed since reset; sticky.

Function
REQ-003 Storage: 2**IDX_W x WAY_NUM entries of CLINE_W bits; every way is written independently.
REQ-004 Accept: a request is accepted when req_valid and req_ready are both 1 on a rising edge; a request with req_ready=0 is ignored, with no stall buffering.
REQ-005 req_ready = 1 only in state READY.
REQ-006 Write: for an accepted request, each way i with req_wr_ways[i]=1 is written with req_wr_cline at req_index; unmasked ways are unchanged.
REQ-007 Read: an accepted request with req_rd_en=1 asserts rd_valid exactly RD_LAT cycles after the accept edge, for one cycle, with rd_clines holding all ways of req_index.
REQ-008 Read-first: a request that both reads and writes returns the contents from before the write.
REQ-009 Back-to-back: a write accepted in cycle t is visible to a read accepted in cycle t+1 or later, at any RD_LAT.
REQ-010 rd_clines holds its last value while rd_valid=0.
REQ-011 Reads are fully pipelined: one read may be accepted every cycle, and rd_valid may stay high continuously.
REQ-012 Accepted requests with req_rd_en=0 and req_wr_ways=0 have no effect.
REQ-013 FSM states are READY, INIT and WAIT_DRAIN.
- INIT: writes zero to all ways of set sweep_cnt each cycle; sweep_cnt counts 0 to 2**IDX_W-1; on the last set the FSM goes to READY, sets init_done and clears init_busy.
- READY + init_req=1: go to WAIT_DRAIN if reads are in flight, otherwise go to INIT with sweep_cnt=0.
- WAIT_DRAIN: go to INIT once the read pipeline is empty; in-flight reads complete normally.
- init_busy = 1 in INIT and WAIT_DRAIN.
REQ-014 init_req is ignored while in INIT or WAIT_DRAIN; it does not restart or queue a sweep.
REQ-015 Simultaneous init_req and req_valid in READY: the request is accepted (req_ready=1 that cycle), and the sweep starts after it drains.
REQ-016 sweep_cnt is IDX_W+1 bits wide so the terminal count does not wrap; a sweep takes exactly 2**IDX_W cycles.
REQ-017 Sweeps never assert rd_valid.

Reset
REQ-018 While rst=0:
- rd_valid=0, rd_clines=0, req_ready=0, init_done=0, sweep_cnt=0, read pipeline cleared.
- init_busy=INIT_EN.
REQ-019 After rst deasserts, the FSM is in INIT if INIT_EN=1, otherwise in READY.
REQ-020 Array contents are not reset; they are defined only after a sweep or a write.
REQ-021 Reset asserted mid-sweep or mid-read aborts the operation; pending reads never produce rd_valid, and the sweep restarts from set 0 (INIT_EN=1).

Verification
REQ-022 Bench shall cover, with IDX_W=4, WAY_NUM=4, CLINE_W=8:
- Reset, INIT_EN=1 -> init_busy=1 for 16 cycles, then req_ready=1 and init_done=1; a read of index 5 returns 0x00000000.
- Write 0xA5 to ways 0b0101 at index 3, then read index 3 next cycle -> rd_clines=0x00A500A5, with RD_LAT=1 and RD_LAT=2.
- Same request reads index 3 and writes 0x3C to way 3 after the previous step -> returns 0x00A500A5; next read returns 0x3CA500A5.
- 16 consecutive reads, indices 0..15 -> rd_valid high 16 consecutive cycles, data in order.
- init_req with 2 reads in flight (RD_LAT=2) -> both rd_valid pulses occur, then a 16-cycle sweep; a later read returns 0.
- rst=0 at sweep set 7 -> outputs zero immediately; after release, the sweep restarts at 0 and lasts the full 16 cycles.

Source files
------------

// File: rtl/hnf_tag_array.sv
// Set-associative tag array: one row of WAY_NUM tag entries per set,
// per-way write mask, read-first pipelined read port (RD_LAT = 1 or 2),
// and a zero-sweep engine that runs after reset and on init_req.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_READY    | accepting requests
// ST_INIT     | zeroing set sweep_cnt_q each cycle, no requests accepted
// ST_WAIT_DRAIN | sweep requested, waiting for in-flight reads to finish
module hnf_tag_array #(
  parameter int IDX_W   = 6,
  parameter int CLINE_W = 28,
  parameter int WAY_NUM = 4,
  parameter int RD_LAT  = 1,
  parameter int INIT_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       init_req,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [IDX_W-1:0]           req_index,
  input  logic                       req_rd_en,
  input  logic [WAY_NUM-1:0]         req_wr_ways,
  input  logic [CLINE_W-1:0]         req_wr_cline,
  output logic                       rd_valid,
  output logic [CLINE_W*WAY_NUM-1:0] rd_clines,
  output logic                       init_busy,
  output logic                       init_done
);

  localparam int DEPTH = 2 ** IDX_W;
  localparam int ROW_W = CLINE_W * WAY_NUM;

  localparam logic [1:0] ST_READY      = 2'd0;
  localparam logic [1:0] ST_INIT       = 2'd1;
  localparam logic [1:0] ST_WAIT_DRAIN = 2'd2;
  localparam logic [1:0] ST_RESET      = (INIT_EN != 0) ? ST_INIT : ST_READY;

  logic [ROW_W-1:0] mem_q [DEPTH];

  logic [1:0]     state_q, state_d;
  logic [IDX_W:0] sweep_cnt_q, sweep_cnt_d;
  logic           init_done_q, init_done_d;

  logic [RD_LAT-1:0] vld_q;
  logic [ROW_W-1:0]  pipe_q [RD_LAT];

  logic accept;
  logic rd_accept;
  logic pipe_busy;
  logic sweep_last;

  // ready is forced low during reset so INIT_EN=0 does not expose READY early
  assign req_ready  = rst && (state_q == ST_READY);
  assign accept     = req_valid && req_ready;
  assign rd_accept  = accept && req_rd_en;
  assign pipe_busy  = |vld_q;
  assign sweep_last = (sweep_cnt_q[IDX_W-1:0] == {IDX_W{1'b1}});

  assign init_busy = (state_q == ST_INIT) || (state_q == ST_WAIT_DRAIN);
  assign init_done = init_done_q;
  assign rd_valid  = vld_q[RD_LAT-1];
  assign rd_clines = pipe_q[RD_LAT-1];

  // Sweep sequencing; a read accepted alongside init_req counts as in flight
  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_READY: begin
        if (init_req) begin
          if (pipe_busy || rd_accept) begin
            state_d = ST_WAIT_DRAIN;
          end else begin
            state_d     = ST_INIT;
            sweep_cnt_d = '0;
          end
        end
      end
      ST_INIT: begin
        if (sweep_last) begin
          state_d     = ST_READY;
          sweep_cnt_d = '0;
          init_done_d = 1'b1;
        end else begin
          sweep_cnt_d = sweep_cnt_q + {{IDX_W{1'b0}}, 1'b1};
        end
      end
      ST_WAIT_DRAIN: begin
        if (!pipe_busy) begin
          state_d     = ST_INIT;
          sweep_cnt_d = '0;
        end
      end
      default: state_d = ST_READY;
    endcase
  end

  // FSM, sweep counter and sticky done flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RESET;
      sweep_cnt_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Array writes: sweep zeroes a whole set, requests update masked ways only
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[sweep_cnt_q[IDX_W-1:0]] <= '0;
    end else if (accept) begin
      for (int w = 0; w < WAY_NUM; w++) begin
        if (req_wr_ways[w]) begin
          mem_q[req_index][w*CLINE_W +: CLINE_W] <= req_wr_cline;
        end
      end
    end
  end

  // Read pipeline: stage 0 samples the pre-write row; last stage holds data when idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      vld_q[0] <= rd_accept;
      if (rd_accept) begin
        pipe_q[0] <= mem_q[req_index];
      end
      for (int k = 1; k < RD_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          pipe_q[k] <= pipe_q[k-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_hnf_tag_array.sv
// Bench for hnf_tag_array: two instances (RD_LAT=1 and RD_LAT=2) share one
// stimulus stream; a timeline model predicts every output on every cycle.
module tb_hnf_tag_array;

  localparam int NI  = 2;
  localparam int INF = 1000000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_req;
  logic        req_valid;
  logic [3:0]  req_index;
  logic        req_rd_en;
  logic [3:0]  req_wr_ways;
  logic [7:0]  req_wr_cline;

  logic        rdy  [NI];
  logic        rdv  [NI];
  logic [31:0] rdd  [NI];
  logic        busy [NI];
  logic        done [NI];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hnf_tag_array #(.IDX_W(4), .CLINE_W(8), .WAY_NUM(4), .RD_LAT(1), .INIT_EN(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .init_req(init_req), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_index(req_index), .req_rd_en(req_rd_en), .req_wr_ways(req_wr_ways),
    .req_wr_cline(req_wr_cline), .rd_valid(rdv[0]), .rd_clines(rdd[0]),
    .init_busy(busy[0]), .init_done(done[0]));

  hnf_tag_array #(.IDX_W(4), .CLINE_W(8), .WAY_NUM(4), .RD_LAT(2), .INIT_EN(1)) u_dut_l2 (
    .clk(clk), .rst(rst), .init_req(init_req), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_index(req_index), .req_rd_en(req_rd_en), .req_wr_ways(req_wr_ways),
    .req_wr_cline(req_wr_cline), .rd_valid(rdv[1]), .rd_clines(rdd[1]),
    .init_busy(busy[1]), .init_done(done[1]));

  // ---------------- timeline model ----------------
  // Slot s = interval after the s-th rising edge. A read accepted at edge e
  // shows up in slot e+LAT-1. A sweep occupying slots S..S+15 makes the block
  // ready again in slot S+16.
  typedef struct {
    int          slot;
    logic [31:0] data;
  } ev_t;

  int          n = 0;
  bit          in_reset = 1'b1;
  logic [7:0]  mem_m [NI][16][4];
  ev_t         evq [NI][$];
  logic [31:0] last_data [NI];
  int          busy_from [NI];
  int          busy_to   [NI];
  int          done_from [NI];
  int          a_last    [NI];

  function automatic int lat_of(int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic bit model_ready(int i, int s);
    return !in_reset && !(s >= busy_from[i] && s <= busy_to[i]);
  endfunction

  function automatic logic [31:0] row_of(int i, int idx);
    return {mem_m[i][idx][3], mem_m[i][idx][2], mem_m[i][idx][1], mem_m[i][idx][0]};
  endfunction

  task automatic zero_mem(int i);
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 4; w++)
        mem_m[i][s][w] = 8'h00;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      last_data[i] = '0;
      busy_from[i] = -INF;
      busy_to[i]   = -INF;
      done_from[i] = INF;
      a_last[i]    = -100;
      zero_mem(i);
    end
  end

  always @(posedge clk) begin : model_edge
    int  e;
    int  s_start;
    bit  rdy_prev;
    bit  rd_now;
    bit  drain;
    int  a_old;
    e = n + 1;
    if (!rst) begin
      in_reset = 1'b1;
      for (int i = 0; i < NI; i++) begin
        evq[i].delete();
        last_data[i] = '0;
        a_last[i]    = -100;
        done_from[i] = INF;
      end
    end else begin
      if (in_reset) begin
        in_reset = 1'b0;
        for (int i = 0; i < NI; i++) begin
          busy_from[i] = e - 1;
          busy_to[i]   = e + 14;
          done_from[i] = e + 15;
          zero_mem(i);
        end
      end
      for (int i = 0; i < NI; i++) begin
        rdy_prev = model_ready(i, e - 1);
        rd_now   = 1'b0;
        a_old    = a_last[i];
        if (rdy_prev && req_valid) begin
          if (req_rd_en) begin
            evq[i].push_back('{slot: e + lat_of(i) - 1, data: row_of(i, int'(req_index))});
            rd_now    = 1'b1;
            a_last[i] = e;
          end
          for (int w = 0; w < 4; w++)
            if (req_wr_ways[w]) mem_m[i][req_index][w] = req_wr_cline;
        end
        if (rdy_prev && init_req) begin
          drain   = rd_now || (a_old + lat_of(i) - 1 >= e - 1);
          s_start = drain ? a_last[i] + lat_of(i) + 1 : e;
          busy_from[i] = e;
          busy_to[i]   = s_start + 15;
          if (done_from[i] == INF) done_from[i] = s_start + 16;
          zero_mem(i);
        end
      end
    end
    n = e;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s slot=%0d: got %h, expected %h", name, n, act, exp);
    end
  endtask

  // one compare process, every cycle, against the model
  always @(negedge clk) begin : compare
    bit exp_v;
    for (int i = 0; i < NI; i++) begin
      if (!rst) begin
        chk($sformatf("rst_ready[%0d]", i), 32'(rdy[i]), 32'd0);
        chk($sformatf("rst_rdvalid[%0d]", i), 32'(rdv[i]), 32'd0);
        chk($sformatf("rst_rdclines[%0d]", i), rdd[i], 32'd0);
        chk($sformatf("rst_busy[%0d]", i), 32'(busy[i]), 32'd1);
        chk($sformatf("rst_done[%0d]", i), 32'(done[i]), 32'd0);
      end else if (!in_reset) begin
        exp_v = (evq[i].size() > 0) && (evq[i][0].slot == n);
        if (exp_v) begin
          last_data[i] = evq[i][0].data;
          void'(evq[i].pop_front());
        end
        chk($sformatf("rdvalid[%0d]", i), 32'(rdv[i]), 32'(exp_v));
        chk($sformatf("rdclines[%0d]", i), rdd[i], last_data[i]);
        chk($sformatf("ready[%0d]", i), 32'(rdy[i]), 32'(model_ready(i, n)));
        chk($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(!model_ready(i, n)));
        chk($sformatf("done[%0d]", i), 32'(done[i]), 32'(n >= done_from[i]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit v, input logic [3:0] idx, input bit rd,
                      input logic [3:0] ways, input logic [7:0] d, input bit ini);
    req_valid    = v;
    req_index    = idx;
    req_rd_en    = rd;
    req_wr_ways  = ways;
    req_wr_cline = d;
    init_req     = ini;
    @(negedge clk);
    #1;
    req_valid = 1'b0; req_index = '0; req_rd_en = 1'b0;
    req_wr_ways = '0; req_wr_cline = '0; init_req = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 1'b0, 4'b0000, 8'h00, 1'b0);
  endtask

  task automatic rd(input logic [3:0] idx);
    step(1'b1, idx, 1'b1, 4'b0000, 8'h00, 1'b0);
  endtask

  task automatic wr(input logic [3:0] idx, input logic [3:0] ways, input logic [7:0] d);
    step(1'b1, idx, 1'b0, ways, d, 1'b0);
  endtask

  task automatic sweep_window();
    for (int c = 0; c < 16; c++) begin
      chk("busy_lit", {30'd0, busy[1], busy[0]}, 32'h3);
      idle();
    end
    chk("ready_lit", {30'd0, rdy[1], rdy[0]}, 32'h3);
    chk("done_lit", {30'd0, done[1], done[0]}, 32'h3);
  endtask

  initial begin
    rst = 1'b0;
    init_req = 1'b0; req_valid = 1'b0; req_index = '0; req_rd_en = 1'b0;
    req_wr_ways = '0; req_wr_cline = '0;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;

    // power-up sweep: 16 busy cycles, then ready and done
    sweep_window();
    rd(4'd5);
    chk("rd5_l1", rdd[0], 32'h0000_0000);
    chk("rd5_l1_v", 32'(rdv[0]), 32'd1);
    idle();
    chk("rd5_l2", rdd[1], 32'h0000_0000);

    // masked write then back-to-back read
    wr(4'd3, 4'b0101, 8'hA5);
    rd(4'd3);
    chk("wr_rd_l1", rdd[0], 32'h00A5_00A5);
    idle();
    chk("wr_rd_l2", rdd[1], 32'h00A5_00A5);

    // read-first on a combined read+write, then the updated row
    step(1'b1, 4'd3, 1'b1, 4'b1000, 8'h3C, 1'b0);
    chk("rfirst_l1", rdd[0], 32'h00A5_00A5);
    rd(4'd3);
    chk("rfirst_l2", rdd[1], 32'h00A5_00A5);
    chk("after_l1", rdd[0], 32'h3CA5_00A5);
    idle();
    chk("after_l2", rdd[1], 32'h3CA5_00A5);

    // request with no read and no write changes nothing
    step(1'b1, 4'd3, 1'b0, 4'b0000, 8'hFF, 1'b0);
    rd(4'd3);
    chk("noop_l1", rdd[0], 32'h3CA5_00A5);

    // fill every set, then 16 back-to-back reads
    for (int i = 0; i < 16; i++) wr(4'(i), 4'b1111, 8'(8'h10 + i));
    for (int i = 0; i < 16; i++) begin
      rd(4'(i));
      chk("stream_l1", rdd[0], {4{8'(8'h10 + i)}});
    end
    idle();
    idle();

    // re-sweep with two reads in flight; an init_req during the sweep is ignored
    rd(4'd1);
    rd(4'd2);
    step(1'b0, 4'd0, 1'b0, 4'b0000, 8'h00, 1'b1);
    repeat (4) idle();
    step(1'b0, 4'd0, 1'b0, 4'b0000, 8'h00, 1'b1);
    repeat (20) idle();
    rd(4'd5);
    chk("resweep_l1", rdd[0], 32'h0000_0000);
    idle();
    chk("resweep_l2", rdd[1], 32'h0000_0000);

    // reset in the middle of a sweep at set 7
    wr(4'd9, 4'b1111, 8'h77);
    rd(4'd9);
    chk("pre_rst_l1", rdd[0], 32'h7777_7777);
    idle();
    idle();
    step(1'b0, 4'd0, 1'b0, 4'b0000, 8'h00, 1'b1);
    repeat (7) idle();
    rst = 1'b0;
    #1;
    chk("midrst_clines", rdd[0] | rdd[1], 32'h0);
    chk("midrst_flags", {28'd0, rdy[1], rdy[0], done[1] | done[0], rdv[1] | rdv[0]}, 32'h0);
    idle();
    idle();
    rst = 1'b1;
    sweep_window();
    rd(4'd9);
    chk("post_rst_l1", rdd[0], 32'h0000_0000);
    idle();
    chk("post_rst_l2", rdd[1], 32'h0000_0000);
    repeat (3) idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
